// File: rtl/serial_divider.sv
// Iterative 32-bit divider for RISC-V DIV/DIVU/REM/REMU: one restoring radix-2 step per cycle.
// Divide-by-zero and signed overflow skip the iteration and finish on the next cycle.
module serial_divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] numerator_i,
  input  logic [31:0] denominator_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [32:0] prem_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic [32:0] shifted_d;
  logic [32:0] diff_d;
  logic [32:0] prem_d;
  logic [31:0] dvd_d;
  logic [31:0] q_final_d;
  logic [31:0] r_final_d;

  logic        req_s;
  logic        is_signed_s;
  logic        num_neg_s;
  logic        den_neg_s;
  logic        den_zero_s;
  logic        ovf_s;
  logic [31:0] num_mag_s;
  logic [31:0] den_mag_s;
  logic        unused_op_s;

  // op_i[1] only selects which result the core consumes; both are always produced
  assign unused_op_s = op_i[1];

  // Request decode and operand magnitude conversion
  always_comb begin
    req_s       = start_i & op_i[2];
    is_signed_s = ~op_i[0];
    num_neg_s   = is_signed_s & numerator_i[31];
    den_neg_s   = is_signed_s & denominator_i[31];
    den_zero_s  = (denominator_i == 32'd0);
    ovf_s       = is_signed_s && (numerator_i == 32'h8000_0000) && (denominator_i == 32'hFFFF_FFFF);
    num_mag_s   = num_neg_s ? (32'd0 - numerator_i) : numerator_i;
    den_mag_s   = den_neg_s ? (32'd0 - denominator_i) : denominator_i;
  end

  // One restoring step: quotient bits shift into the dividend register as its MSBs leave
  always_comb begin
    shifted_d = {prem_q[31:0], dvd_q[31]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    if (!diff_d[32]) begin
      prem_d = diff_d;
      dvd_d  = {dvd_q[30:0], 1'b1};
    end else begin
      prem_d = shifted_d;
      dvd_d  = {dvd_q[30:0], 1'b0};
    end
    q_final_d = q_neg_q ? (32'd0 - dvd_d) : dvd_d;
    r_final_d = r_neg_q ? (32'd0 - prem_d[31:0]) : prem_d[31:0];
  end

  // Control FSM with datapath and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      prem_q      <= 33'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            if (den_zero_s) begin
              quotient_q  <= 32'hFFFF_FFFF;
              remainder_q <= numerator_i;
              state_q     <= DONE;
            end else if (ovf_s) begin
              quotient_q  <= 32'h8000_0000;
              remainder_q <= 32'd0;
              state_q     <= DONE;
            end else begin
              dvd_q   <= num_mag_s;
              dvs_q   <= den_mag_s;
              prem_q  <= 33'd0;
              cnt_q   <= 6'd0;
              q_neg_q <= num_neg_s ^ den_neg_s;
              r_neg_q <= num_neg_s;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            quotient_q  <= q_final_d;
            remainder_q <= r_final_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q == CALC) || (state_q == DONE);

endmodule
